// File: rtl/fei4_rx_pkg.sv
// Shared definitions for the front-end receive path: K28.1 comma codes and
// the word-alignment state type.
package fei4_rx_pkg;

   localparam logic [9:0] COMMA_RDN = 10'b0011111001;
   localparam logic [9:0] COMMA_RDP = 10'b1100000110;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } align_state_e;

endpackage

// File: rtl/rx_comma_match.sv
// Combinational K28.1 detector (either running disparity) on a 10b window.
module rx_comma_match
   import fei4_rx_pkg::*;
(
   input  logic [9:0] sym_i,
   output logic       match_o
);

   assign match_o = (sym_i == COMMA_RDN) || (sym_i == COMMA_RDP);

endmodule

// File: rtl/rx_word_align.sv
// Serial-to-10b word aligner: hunts for K28.1, verifies a run of aligned
// commas, then emits one aligned symbol per boundary while tracking lock.
module rx_word_align
   import fei4_rx_pkg::*;
#(
   parameter int LOCK_COMMAS = 4,
   parameter int LOSS_COMMAS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   input  logic       din_valid,
   input  logic       enable,
   output logic [9:0] word,
   output logic       word_valid,
   output logic       is_comma,
   output logic       locked,
   output logic [7:0] lock_loss_cnt
);

   localparam logic [3:0] LOCK_N = 4'(LOCK_COMMAS);
   localparam logic [3:0] LOSS_N = 4'(LOSS_COMMAS);

   logic [9:0]   sr_q, sr_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         new_a_q, new_a_d, bnd_a_q, bnd_a_d;
   logic         new_b_q, new_b_d, bnd_b_q, bnd_b_d;
   logic         match_q, match_d;
   logic [9:0]   sym_q;
   logic         comma_hit;
   logic         realign;

   align_state_e state_q, state_d;
   logic [3:0]   good_q, good_d, miss_q, miss_d;
   logic [9:0]   word_q, word_d;
   logic         word_valid_q, word_valid_d;
   logic         is_comma_q, is_comma_d;
   logic         locked_q, locked_d;
   logic [7:0]   loss_q, loss_d;

   rx_comma_match u_comma_match (
      .sym_i   (sr_q),
      .match_o (comma_hit)
   );

   // Stage A tracks the bit just shifted in, stage B carries its registered
   // compare result to the FSM. A realign decided for the stage-B bit
   // recounts the up to two bits that arrived after it.
   always_comb begin
      sr_d    = din_valid ? {sr_q[8:0], din} : sr_q;
      cnt_d   = cnt_q;
      bnd_a_d = 1'b0;
      if (din_valid) begin
         bnd_a_d = (cnt_q == 4'd9);
         cnt_d   = (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
      end
      new_a_d = din_valid & enable;
      new_b_d = new_a_q;
      bnd_b_d = bnd_a_q;
      match_d = comma_hit & new_a_q;
      if (!enable) begin
         cnt_d   = 4'd0;
         bnd_a_d = 1'b0;
         bnd_b_d = 1'b0;
         new_b_d = 1'b0;
         match_d = 1'b0;
      end else if (realign) begin
         cnt_d   = {3'b000, new_a_q} + {3'b000, din_valid};
         bnd_a_d = 1'b0;
         bnd_b_d = 1'b0;
      end
   end

   always_comb begin
      state_d      = state_q;
      good_d       = good_q;
      miss_d       = miss_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      is_comma_d   = is_comma_q;
      loss_d       = loss_q;
      realign      = 1'b0;

      if (!enable) begin
         state_d = ST_HUNT;
         good_d  = 4'd0;
         miss_d  = 4'd0;
      end else if (new_b_q) begin
         case (state_q)
            ST_HUNT: begin
               if (match_q) begin
                  state_d = ST_VERIFY;
                  realign = 1'b1;
                  good_d  = 4'd1;
               end
            end
            ST_VERIFY: begin
               if (bnd_b_q) begin
                  if (match_q) begin
                     good_d = good_q + 4'd1;
                     if (good_q + 4'd1 >= LOCK_N) begin
                        state_d = ST_LOCKED;
                        good_d  = 4'd0;
                        miss_d  = 4'd0;
                     end
                  end else begin
                     state_d = ST_HUNT;
                     good_d  = 4'd0;
                  end
               end else if (match_q) begin
                  realign = 1'b1;
                  good_d  = 4'd1;
               end
            end
            ST_LOCKED: begin
               if (bnd_b_q) begin
                  word_valid_d = 1'b1;
                  word_d       = sym_q;
                  is_comma_d   = match_q;
                  if (match_q) miss_d = 4'd0;
               end else if (match_q) begin
                  miss_d = miss_q + 4'd1;
                  // Loss keeps the current count; the next comma in HUNT realigns.
                  if (miss_q + 4'd1 >= LOSS_N) begin
                     state_d = ST_HUNT;
                     miss_d  = 4'd0;
                     good_d  = 4'd0;
                     if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                  end
               end
            end
            default: begin
               state_d = ST_HUNT;
               good_d  = 4'd0;
               miss_d  = 4'd0;
            end
         endcase
      end

      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q         <= 10'd0;
         cnt_q        <= 4'd0;
         new_a_q      <= 1'b0;
         bnd_a_q      <= 1'b0;
         new_b_q      <= 1'b0;
         bnd_b_q      <= 1'b0;
         match_q      <= 1'b0;
         sym_q        <= 10'd0;
         state_q      <= ST_HUNT;
         good_q       <= 4'd0;
         miss_q       <= 4'd0;
         word_q       <= 10'd0;
         word_valid_q <= 1'b0;
         is_comma_q   <= 1'b0;
         locked_q     <= 1'b0;
         loss_q       <= 8'd0;
      end else begin
         sr_q         <= sr_d;
         cnt_q        <= cnt_d;
         new_a_q      <= new_a_d;
         bnd_a_q      <= bnd_a_d;
         new_b_q      <= new_b_d;
         bnd_b_q      <= bnd_b_d;
         match_q      <= match_d;
         sym_q        <= sr_q;
         state_q      <= state_d;
         good_q       <= good_d;
         miss_q       <= miss_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         is_comma_q   <= is_comma_d;
         locked_q     <= locked_d;
         loss_q       <= loss_d;
      end
   end

   assign word          = word_q;
   assign word_valid    = word_valid_q;
   assign is_comma      = is_comma_q;
   assign locked        = locked_q;
   assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_rx_word_align.sv
// Randomized bench for rx_word_align against a bit-serial reference model
// whose per-bit results are delayed two clocks to line up with the outputs.
module tb_rx_word_align;

   localparam int LOCK_N = 4;
   localparam int LOSS_N = 2;
   localparam logic [9:0] K_NEG = 10'b0011111001;
   localparam logic [9:0] K_POS = 10'b1100000110;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       enable = 1'b1;
   logic [9:0] word;
   logic       word_valid;
   logic       is_comma;
   logic       locked;
   logic [7:0] lock_loss_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int sp_expect = 0;
   int sp_from = 0;
   int sp_idx = 0;
   int sp_last = 0;
   bit rd_pos = 1'b1;

   rx_word_align #(
      .LOCK_COMMAS (LOCK_N),
      .LOSS_COMMAS (LOSS_N)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .din           (din),
      .din_valid     (din_valid),
      .enable        (enable),
      .word          (word),
      .word_valid    (word_valid),
      .is_comma      (is_comma),
      .locked        (locked),
      .lock_loss_cnt (lock_loss_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: processes one received bit at a time with no pipeline.
   typedef enum {M_HUNT, M_VERIFY, M_LOCKED} mstate_e;
   typedef struct {
      logic       wv;
      logic [9:0] w;
      logic       c;
      logic       lk;
      int         loss;
   } exp_t;

   mstate_e    m_st = M_HUNT;
   logic [9:0] m_hist = 10'd0;
   int         m_since = 0;
   int         m_good = 0;
   int         m_miss = 0;
   int         m_loss = 0;
   exp_t       pipe [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_align_clear();
      m_st    = M_HUNT;
      m_since = 0;
      m_good  = 0;
      m_miss  = 0;
   endtask

   task automatic pipe_clear();
      for (int i = 0; i < 2; i++) begin
         pipe[i].wv   = 1'b0;
         pipe[i].w    = 10'd0;
         pipe[i].c    = 1'b0;
         pipe[i].lk   = 1'b0;
         pipe[i].loss = m_loss;
      end
   endtask

   task automatic model_bit(input logic b, output exp_t r);
      logic cm;
      logic at_bnd;
      m_hist = {m_hist[8:0], b};
      m_since++;
      at_bnd = (m_since == 10);
      if (at_bnd) m_since = 0;
      cm = (m_hist == K_NEG) || (m_hist == K_POS);
      r.wv = 1'b0;
      r.w  = m_hist;
      r.c  = cm;
      case (m_st)
         M_HUNT: if (cm) begin
            m_st = M_VERIFY; m_since = 0; m_good = 1;
         end
         M_VERIFY: begin
            if (at_bnd) begin
               if (cm) begin
                  m_good++;
                  if (m_good >= LOCK_N) begin m_st = M_LOCKED; m_miss = 0; end
               end else begin
                  m_st = M_HUNT; m_good = 0;
               end
            end else if (cm) begin
               m_since = 0; m_good = 1;
            end
         end
         default: begin
            if (at_bnd) begin
               r.wv = 1'b1;
               if (cm) m_miss = 0;
            end else if (cm) begin
               m_miss++;
               if (m_miss >= LOSS_N) begin
                  m_st = M_HUNT; m_miss = 0; m_good = 0;
                  if (m_loss < 255) m_loss++;
               end
            end
         end
      endcase
      r.lk   = (m_st == M_LOCKED);
      r.loss = m_loss;
   endtask

   // Called on a falling edge: drive, clock once, then compare on the next falling edge.
   task automatic step(input logic b, input logic v, input logic e);
      exp_t r;
      exp_t want;
      din = b; din_valid = v; enable = e;
      @(posedge clk);
      r.wv = 1'b0; r.w = 10'd0; r.c = 1'b0;
      r.lk = (m_st == M_LOCKED); r.loss = m_loss;
      if (!e) begin
         model_align_clear();
         r.lk = 1'b0;
         for (int i = 0; i < 2; i++) begin pipe[i].wv = 1'b0; pipe[i].lk = 1'b0; end
      end else if (v) begin
         model_bit(b, r);
      end
      want    = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = r;
      if (!e) begin want.wv = 1'b0; want.lk = 1'b0; end
      @(negedge clk);
      cyc++;
      check("word_valid", 32'(word_valid), 32'(want.wv));
      check("locked", 32'(locked), 32'(want.lk));
      check("lock_loss_cnt", 32'(lock_loss_cnt), want.loss);
      if (want.wv) begin
         check("word", 32'(word), 32'(want.w));
         check("is_comma", 32'(is_comma), 32'(want.c));
      end
      if (word_valid) begin
         $display("word %03h is_comma %0d locked %0d loss %0d cycle %0d",
                  word, is_comma, locked, lock_loss_cnt, cyc);
         if (sp_expect != 0) begin
            if (sp_idx >= sp_from) check("wv_spacing", cyc - sp_last, sp_expect);
            sp_idx++;
         end
         sp_last = cyc;
      end
   endtask

   // mode 0: continuous bits, 1: random gaps, 2: din_valid toggling every cycle.
   task automatic send_sym(input logic [9:0] s, input int mode);
      for (int i = 9; i >= 0; i--) begin
         if (mode == 1) begin
            int g;
            g = ($urandom_range(99) < 30) ? int'($urandom_range(1, 3)) : 0;
            for (int k = 0; k < g; k++) step(1'($urandom), 1'b0, 1'b1);
         end
         step(s[i], 1'b1, 1'b1);
         if (mode == 2) step(1'($urandom), 1'b0, 1'b1);
      end
   endtask

   task automatic send_commas(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         rd_pos = !rd_pos;
         send_sym(rd_pos ? K_POS : K_NEG, mode);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) step(1'($urandom), 1'b0, 1'b1);
   endtask

   // Asserts rst between edges and checks the outputs clear without a clock.
   task automatic do_reset();
      din_valid = 1'b0; enable = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("rst_word", 32'(word), 32'd0);
      check("rst_word_valid", 32'(word_valid), 32'd0);
      check("rst_is_comma", 32'(is_comma), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_loss", 32'(lock_loss_cnt), 32'd0);
      m_hist = 10'd0;
      m_loss = 0;
      model_align_clear();
      pipe_clear();
      rd_pos = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      pipe_clear();
      @(negedge clk);
      do_reset();

      // Comma stream at a 3-bit offset: lock on the 4th aligned comma, strobe every 10 clk.
      for (int i = 0; i < 3; i++) step(1'($urandom), 1'b1, 1'b1);
      sp_expect = 10; sp_from = 1; sp_idx = 0;
      send_commas(8, 0);
      check("lock_comma_stream", 32'(locked), 32'd1);

      // Data words while locked.
      sp_expect = 0;
      for (int i = 0; i < 4; i++) send_sym(10'h155, 0);
      send_commas(2, 0);
      check("lock_after_data", 32'(locked), 32'd1);

      // One duplicated bit: two misaligned commas drop lock, then relock at the new phase.
      step(rd_pos ? K_POS[0] : K_NEG[0], 1'b1, 1'b1);
      send_commas(8, 0);
      check("slip_loss_cnt", 32'(lock_loss_cnt), 32'd1);
      check("slip_relock", 32'(locked), 32'd1);

      // din_valid toggling: strobe every 20 clk.
      sp_expect = 20; sp_from = 2; sp_idx = 0;
      send_commas(6, 2);
      sp_expect = 0;

      // One-cycle enable drop.
      drain();
      step(1'b0, 1'b0, 1'b0);
      check("enable_unlock", 32'(locked), 32'd0);
      send_commas(8, 0);
      check("enable_relock", 32'(locked), 32'd1);
      check("enable_loss_kept", 32'(lock_loss_cnt), 32'd1);

      // Randomized mix of commas and data with random din_valid gaps.
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(99) < 40) send_commas(1, 1);
         else send_sym(10'($urandom), 1);
      end

      // Reset mid-symbol while locked, then reacquire.
      send_commas(8, 0);
      for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b1);
      drain();
      do_reset();
      drain();
      send_commas(8, 0);
      check("reset_relock", 32'(locked), 32'd1);
      check("reset_loss_zero", 32'(lock_loss_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rx_word_align.md
RX_WORD_ALIGN -- requirements
Module: rx_word_align

Interface
REQ-001 SHALL have parameter LOCK_COMMAS, default 4: consecutive aligned commas needed to declare lock (range 1..15).
REQ-002 SHALL have parameter LOSS_COMMAS, default 2: consecutive misaligned commas that drop lock (range 1..15).
REQ-003 clk  input  1  160 MHz recovered-data clock.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 din  input  1  recovered serial bit from the oversampling CDR stage.
REQ-006 din_valid  input  1  din holds a new bit this cycle (tie high if unused).
REQ-007 enable  input  1  alignment enable; low forces HUNT.
REQ-008 word  output  10  aligned 10b symbol; first-received bit in word[9].
REQ-009 word_valid  output  1  one-cycle strobe qualifying word.
REQ-010 is_comma  output  1  word is K28.1 (either disparity), qualified by word_valid.
REQ-011 locked  output  1  alignment locked.
REQ-012 lock_loss_cnt  output  8  saturating count of LOCKED->HUNT transitions.

Function
REQ-013 On each din_valid cycle, shift register sr SHALL update as sr <= {sr[8:0], din}; sr holds when din_valid is low.
REQ-014 Comma match SHALL be sr == 10'b0011111001 or sr == 10'b1100000110, evaluated one cycle after the sr update (registered compare stage).
REQ-015 Bit counter cnt (0..9) SHALL increment on each din_valid and wrap 9->0; a boundary occurs when the bit making cnt wrap is shifted in.
REQ-016 FSM states SHALL be HUNT, VERIFY, LOCKED; reset state HUNT.
REQ-017 HUNT: comma match at any position -> VERIFY, cnt realigned so that the matching bit is a boundary, good_cnt=1.
REQ-018 VERIFY: comma at boundary -> good_cnt+1; when good_cnt reaches LOCK_COMMAS -> LOCKED. Non-comma at boundary -> HUNT. Comma off boundary -> stay VERIFY, realign cnt, good_cnt=1.
REQ-019 LOCKED: each boundary SHALL output word=sr, word_valid=1 for exactly one cycle, is_comma=match; latency 2 clk edges from the edge sampling the symbol's last bit to word_valid high.
REQ-020 LOCKED: misaligned comma increments miss_cnt; aligned comma clears it; miss_cnt reaching LOSS_COMMAS -> HUNT, lock_loss_cnt+1 (saturate at 255), no realignment in that cycle.
REQ-021 LOCKED: the transition to HUNT SHALL suppress word_valid for the symbol at which the loss is detected.
REQ-022 locked SHALL be 1 only in LOCKED, registered; word_valid SHALL be 0 in HUNT and VERIFY.
REQ-023 enable low SHALL force HUNT on the next edge and clear cnt, good_cnt, miss_cnt, word_valid, locked; lock_loss_cnt is retained and not incremented.
REQ-024 din_valid low at a would-be boundary SHALL delay the boundary until the 10th valid bit; no strobe without a completing valid bit.
REQ-025 Boundary and misaligned comma cannot coincide; a comma at a boundary is always treated as aligned.

Reset
REQ-026 rst SHALL asynchronously set: state HUNT, sr 0, cnt 0, good_cnt 0, miss_cnt 0, word 0, word_valid 0, is_comma 0, locked 0, lock_loss_cnt 0.
REQ-027 rst asserted mid-symbol SHALL discard partial symbols; after release, lock SHALL be reacquired only through HUNT/VERIFY.

Structure
REQ-028 Package fei4_rx_pkg SHALL hold the COMMA_RDN/COMMA_RDP constants and the align-state enum type.
REQ-029 Comma compare SHALL be one sub-module rx_comma_match (10b in, match out); all else in rx_word_align.
REQ-030 Implementation SHALL use only clk; no clk_2x logic.

Verification
REQ-031 Continuous K28.1 (RD- then RD+ alternating) at 3-bit offset, din_valid=1 -> locked high after 4th aligned comma; word_valid every 10 clk; is_comma=1.
REQ-032 Locked, then 40 data bits 0x155 pattern -> word=10'h155 x4, is_comma=0, locked stays 1.
REQ-033 Locked, inject bit slip (one duplicate bit) followed by commas -> 2nd misaligned comma drops locked, lock_loss_cnt=1, relock after 4 commas at new phase.
REQ-034 din_valid toggling 1/0 every cycle with comma stream -> word_valid every 20 clk, same words as REQ-031.
REQ-035 Locked, pulse enable low 1 cycle -> locked=0 next cycle, lock_loss_cnt unchanged, relock after 4 commas.
REQ-036 Assert rst mid-symbol while locked -> all outputs 0 immediately; no word_valid until relock.
